// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
// Accumulates statistics over a stream of le/eq/gr results from an upstream
// comparator, and exposes a frozen snapshot through a four-phase handshake.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous, active-high reset
//   in_valid   le/eq/gr carry a valid compare result this cycle
//   le/eq/gr   comparator flags (in1<in2, in1==in2, in1>in2)
//   clr        synchronous clear of every live counter and the run state
//   rd_req     four-phase snapshot request
//   rd_ack     snapshot valid and held
//   le_cnt, eq_cnt, gr_cnt, run_max, err_cnt   snapshot outputs
//   run_hit    one-cycle pulse when the current eq run reaches RUN_THRESH
//   fsm_state  debug view of the read handshake FSM (0 IDLE, 1 ACK, 2 WAIT_LOW)
//
// Handshake: rd_req rises -> next cycle rd_ack=1 with the snapshot held.
// rd_ack stays high until rd_req falls, then one WAIT_LOW cycle (rd_req
// ignored) precedes the return to IDLE, where a high rd_req starts a new read.
module cmp_result_tracker #(
  parameter int CNT_W      = 8,
  parameter int RUN_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             le,
  input  logic             eq,
  input  logic             gr,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] le_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gr_cnt,
  output logic [CNT_W-1:0] run_max,
  output logic [CNT_W-1:0] err_cnt,
  output logic             run_hit,
  output logic [1:0]       fsm_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_T   = CNT_W'(RUN_THRESH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t state;

  // Live counters
  logic [CNT_W-1:0] le_l, eq_l, gr_l, err_l, run_l, max_l;
  // Next live values, including the sample of the current cycle
  logic [CNT_W-1:0] le_n, eq_n, gr_n, err_n, run_n, max_n;
  logic             hit_n;
  logic             take;
  logic             one_hot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // A sample arriving together with clr is discarded, so with clr the
  // "next" values equal the current live values.
  assign take    = in_valid && !clr;
  assign one_hot = ({le, eq, gr} == 3'b100) || ({le, eq, gr} == 3'b010) ||
                   ({le, eq, gr} == 3'b001);

  always_comb begin
    le_n  = le_l;
    eq_n  = eq_l;
    gr_n  = gr_l;
    err_n = err_l;
    run_n = run_l;
    hit_n = 1'b0;
    if (take) begin
      if (one_hot) begin
        if (le) le_n = sat_inc(le_l);
        if (gr) gr_n = sat_inc(gr_l);
        if (eq) begin
          eq_n  = sat_inc(eq_l);
          run_n = sat_inc(run_l);
          // run_l != RUN_T keeps a run saturated at RUN_THRESH from re-firing
          hit_n = (run_n == RUN_T) && (run_l != RUN_T);
        end else begin
          run_n = '0;
        end
      end else begin
        err_n = sat_inc(err_l);
        run_n = '0;
      end
    end
    max_n = (run_n > max_l) ? run_n : max_l;
  end

  // Live statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      le_l    <= '0;
      eq_l    <= '0;
      gr_l    <= '0;
      err_l   <= '0;
      run_l   <= '0;
      max_l   <= '0;
      run_hit <= 1'b0;
    end else if (clr) begin
      le_l    <= '0;
      eq_l    <= '0;
      gr_l    <= '0;
      err_l   <= '0;
      run_l   <= '0;
      max_l   <= '0;
      run_hit <= 1'b0;
    end else begin
      le_l    <= le_n;
      eq_l    <= eq_n;
      gr_l    <= gr_n;
      err_l   <= err_n;
      run_l   <= run_n;
      max_l   <= max_n;
      run_hit <= hit_n;
    end
  end

  // Read handshake FSM and snapshot registers. Copying the *_n values picks
  // up a same-cycle sample, and yields the pre-clear values when clr is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_ack  <= 1'b0;
      le_cnt  <= '0;
      eq_cnt  <= '0;
      gr_cnt  <= '0;
      run_max <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            le_cnt  <= le_n;
            eq_cnt  <= eq_n;
            gr_cnt  <= gr_n;
            run_max <= max_n;
            err_cnt <= err_n;
            rd_ack  <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          if (!rd_req) begin
            rd_ack <= 1'b0;
            state  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          rd_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rd_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed testbench for cmp_result_tracker (CNT_W=8, RUN_THRESH=4).
module tb_cmp_result_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, le, eq, gr, clr, rd_req;
  logic       rd_ack, run_hit;
  logic [7:0] le_cnt, eq_cnt, gr_cnt, run_max, err_cnt;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;
  int hits;

  cmp_result_tracker #(.CNT_W(8), .RUN_THRESH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .le(le), .eq(eq), .gr(gr),
    .clr(clr), .rd_req(rd_req), .rd_ack(rd_ack), .le_cnt(le_cnt),
    .eq_cnt(eq_cnt), .gr_cnt(gr_cnt), .run_max(run_max), .err_cnt(err_cnt),
    .run_hit(run_hit), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample {l,e,g} for one cycle, then drop in_valid.
  task automatic send(input logic v, input logic [2:0] f);
    in_valid = v;
    {le, eq, gr} = f;
    tick();
    if (run_hit) hits++;
    in_valid = 1'b0;
    {le, eq, gr} = 3'b000;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Full four-phase read; snapshot checked while rd_ack is high.
  task automatic do_read(input string tag, input logic [7:0] e_le, input logic [7:0] e_eq,
                         input logic [7:0] e_gr, input logic [7:0] e_max, input logic [7:0] e_err);
    rd_req = 1'b1;
    tick();
    chk({tag, "_ack"}, rd_ack, 1);
    chk({tag, "_le"}, le_cnt, e_le);
    chk({tag, "_eq"}, eq_cnt, e_eq);
    chk({tag, "_gr"}, gr_cnt, e_gr);
    chk({tag, "_max"}, run_max, e_max);
    chk({tag, "_err"}, err_cnt, e_err);
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; le = 1'b0; eq = 1'b0; gr = 1'b0;
    clr = 1'b0; rd_req = 1'b0; hits = 0;
    tick();
    tick();
    // Reset state
    chk("rst_ack", rd_ack, 0);
    chk("rst_hit", run_hit, 0);
    chk("rst_state", fsm_state, 0);
    chk("rst_snap", {le_cnt, eq_cnt, gr_cnt, run_max}, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;
    tick();

    // 3 le, 2 gr, 1 eq
    repeat (3) send(1'b1, 3'b100);
    repeat (2) send(1'b1, 3'b001);
    send(1'b1, 3'b010);
    send(1'b0, 3'b100);  // invalid cycle is ignored
    do_read("basic", 8'd3, 8'd1, 8'd2, 8'd1, 8'd0);

    // Runs: 5 eq, gr, 4 eq -> two run_hit pulses on sample 4 of each run
    do_clr();
    hits = 0;
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 3'b010);
      if (i == 4) chk("hit_run1_s4", run_hit, 1);
      if (i == 5) chk("hit_run1_s5", run_hit, 0);
    end
    send(1'b1, 3'b001);
    for (int i = 1; i <= 4; i++) send(1'b1, 3'b010);
    tick();
    chk("hit_total", hits, 2);
    do_read("runs", 8'd0, 8'd9, 8'd1, 8'd5, 8'd0);

    // Error patterns break the run: 2 eq, 000/110/111, 3 eq -> no hit, max 3
    do_clr();
    hits = 0;
    repeat (2) send(1'b1, 3'b010);
    send(1'b1, 3'b000);
    send(1'b1, 3'b110);
    send(1'b1, 3'b111);
    repeat (3) send(1'b1, 3'b010);
    tick();
    chk("err_nohit", hits, 0);
    do_read("err", 8'd0, 8'd5, 8'd0, 8'd3, 8'd3);

    // Saturation: 300 le -> 255
    do_clr();
    repeat (300) send(1'b1, 3'b100);
    do_read("sat", 8'd255, 8'd0, 8'd0, 8'd0, 8'd0);

    // Snapshot frozen while rd_req held; WAIT_LOW ignores rd_req
    do_clr();
    rd_req = 1'b1;
    tick();
    chk("frz_ack", rd_ack, 1);
    repeat (10) send(1'b1, 3'b001);
    chk("frz_gr", gr_cnt, 0);
    chk("frz_ack_hold", rd_ack, 1);
    do_clr();  // clr leaves the snapshot and rd_ack alone
    chk("frz_clr_ack", rd_ack, 1);
    repeat (10) send(1'b1, 3'b001);
    rd_req = 1'b0;
    tick();
    chk("wl_ack", rd_ack, 0);
    chk("wl_state", fsm_state, 2);
    rd_req = 1'b1;
    tick();
    chk("wl_ignore", rd_ack, 0);
    tick();
    chk("rd2_ack", rd_ack, 1);
    chk("rd2_gr", gr_cnt, 10);

    // Async reset mid-handshake
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", rd_ack, 0);
    chk("arst_snap", {le_cnt, eq_cnt, gr_cnt, run_max, err_cnt}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_reread_ack", rd_ack, 1);
    chk("arst_reread_gr", gr_cnt, 0);
    rd_req = 1'b0;
    tick();
    tick();

    // clr together with rd_req: snapshot holds pre-clear counts
    repeat (2) send(1'b1, 3'b100);
    clr = 1'b1; rd_req = 1'b1; in_valid = 1'b1; {le, eq, gr} = 3'b001;
    tick();
    clr = 1'b0; in_valid = 1'b0; {le, eq, gr} = 3'b000;
    chk("clrrd_ack", rd_ack, 1);
    chk("clrrd_le", le_cnt, 2);
    chk("clrrd_gr", gr_cnt, 0);
    rd_req = 1'b0;
    tick();
    tick();
    do_read("postclr", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
CMP_RESULT_TRACKER -- requirements
Module: cmp_result_tracker

Interface
REQ-001 Parameter CNT_W, default 8: width of every counter and snapshot output.
REQ-002 Parameter RUN_THRESH, default 4: equal-run length that fires run_hit; legal range 1..2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  le/eq/gr carry a valid compare result this cycle.
REQ-006 le  input  1  upstream 8-bit comparator result in1 < in2.
REQ-007 eq  input  1  upstream 8-bit comparator result in1 == in2.
REQ-008 gr  input  1  upstream 8-bit comparator result in1 > in2.
REQ-009 clr  input  1  synchronous clear of all live counters.
REQ-010 rd_req  input  1  four-phase snapshot read request.
REQ-011 rd_ack  output  1  snapshot valid and held; four-phase acknowledge.
REQ-012 le_cnt, eq_cnt, gr_cnt  output  CNT_W each  snapshot of saturating per-flag counts.
REQ-013 run_max  output  CNT_W  snapshot of the longest consecutive-eq run.
REQ-014 err_cnt  output  CNT_W  snapshot of the count of invalid flag patterns.
REQ-015 run_hit  output  1  one-cycle pulse when the current eq run reaches RUN_THRESH.

Function
REQ-016 A valid sample is one where in_valid=1; cycles with in_valid=0 change no counter and no run state.
REQ-017 A valid sample with exactly one of le/eq/gr set increments the matching live counter by 1.
REQ-018 A valid sample that is not one-hot (zero flags or more than one flag) increments only the live error counter; it touches no flag counter.
REQ-019 All live counters saturate at 2^CNT_W-1 and never wrap.
REQ-020 Live run counter: +1 (saturating) on a valid one-hot eq; reset to 0 on any valid non-eq sample, including error samples.
REQ-021 Live run_max takes max(run_max, new run) in the same cycle as the run increment.
REQ-022 run_hit is registered: it is high in the cycle after the sample that makes the run counter equal RUN_THRESH.
REQ-023 run_hit fires once per run; it does not re-fire until the run is broken and rebuilt.
REQ-024 clr=1 zeroes all live counters, the run counter and live run_max next edge; a sample in the same cycle is discarded.
REQ-025 clr does not affect the snapshot outputs or rd_ack.
REQ-026 FSM states: IDLE, ACK, WAIT_LOW.
REQ-027 IDLE: on rd_req=1, copy all live values into the snapshot registers and go to ACK.
REQ-028 The copied snapshot includes any sample accepted in the same cycle as the copy.
REQ-029 ACK: rd_ack=1; snapshot held; go to WAIT_LOW when rd_req=0.
REQ-030 WAIT_LOW: rd_ack=0 for one cycle, then go to IDLE; rd_req is ignored in this state.
REQ-031 Earliest rd_ack is the cycle after rd_req first rises, a latency of 1 cycle.
REQ-032 Sample counting continues in every FSM state; only the snapshot registers are frozen outside the IDLE->ACK copy.
REQ-033 clr and rd_req in the same cycle: the snapshot captures the values before the clear.

Reset
REQ-034 rst=1 immediately forces FSM=IDLE, all live counters and run state to 0, all snapshot outputs to 0, rd_ack=0 and run_hit=0.
REQ-035 Reset mid-handshake drops rd_ack at once; after reset, a still-high rd_req starts a new read from IDLE.

Verification
REQ-036 Reset; 3 valid le, 2 valid gr, 1 valid eq; rd_req -> rd_ack next cycle; le_cnt=3, gr_cnt=2, eq_cnt=1, err_cnt=0, run_max=1.
REQ-037 Five consecutive valid eq, then one gr, then 4 eq -> run_hit pulses exactly twice (sample 4 of each run); snapshot run_max=5.
REQ-038 Valid samples with flags 000, 110 and 111 -> err_cnt=3; flag counters unchanged; run counter reset.
REQ-039 300 valid le with CNT_W=8 -> le_cnt=255, no wrap.
REQ-040 Hold rd_req high while feeding 10 gr -> gr_cnt stays frozen until rd_req falls and a new request is made, which then shows +10.
REQ-041 Assert rst while rd_ack=1 -> rd_ack=0 and all outputs 0 in the same cycle; clr together with rd_req -> the snapshot holds the pre-clear counts.
